// File: rtl/imem_wb_loader.sv
// Wishbone slave that programs and reads back the SLRV instruction SRAM through its
// read/write port 0, and owns the HOLD bit that keeps the core in reset during loading.
module imem_wb_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              wb_clk_i,
  input  logic              reset_n,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              sram_csb0,
  output logic              sram_web0,
  output logic [3:0]        sram_wmask0,
  output logic [ADDR_W-1:0] sram_addr0,
  output logic [DATA_W-1:0] sram_din0,
  input  logic [DATA_W-1:0] sram_dout0,
  output logic              core_hold
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RWAIT  = 2'd2,
    ACK    = 2'd3
  } state_t;

  localparam logic [9:0] CTRL_WORD  = 10'h200;
  localparam logic [9:0] WCOUNT_MAX = 10'd1023;

  state_t     state;
  state_t     stateNext;
  logic [9:0] wcount;

  logic windowHit;
  logic isSram;
  logic isCtrl;
  logic req;

  logic sramGo;
  logic ctrlWr;
  logic ctrlRd;
  logic wcountInc;
  logic doutCap;
  logic enterAck;

  logic unusedAdrBits;

  function automatic logic [9:0] satInc(input logic [9:0] v);
    return (v == WCOUNT_MAX) ? v : v + 10'd1;
  endfunction

  function automatic logic [31:0] ctrlReadWord(input logic hold, input logic [9:0] count);
    return {6'd0, count, 15'd0, hold};
  endfunction

  assign unusedAdrBits = &{1'b0, wbs_adr_i[1:0]};

  assign windowHit = (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  assign isSram    = ~wbs_adr_i[11];
  assign isCtrl    = (wbs_adr_i[11:2] == CTRL_WORD);
  assign req       = wbs_cyc_i & wbs_stb_i & windowHit;

  always_ff @(posedge wb_clk_i) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    sramGo    = 1'b0;
    ctrlWr    = 1'b0;
    ctrlRd    = 1'b0;
    wcountInc = 1'b0;
    doutCap   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (isSram) begin
            // Writes while the core runs are acknowledged but never reach the SRAM.
            if (wbs_we_i && !core_hold) begin
              stateNext = ACK;
            end else begin
              sramGo    = 1'b1;
              stateNext = ACCESS;
            end
          end else begin
            ctrlWr    = wbs_we_i & isCtrl;
            ctrlRd    = ~wbs_we_i & isCtrl;
            stateNext = ACK;
          end
        end
      end
      ACCESS: begin
        // The SRAM cycle is already committed, so the count moves even on abort.
        wcountInc = ~sram_web0;
        if (!wbs_cyc_i) begin
          stateNext = IDLE;
        end else if (!sram_web0) begin
          stateNext = ACK;
        end else begin
          stateNext = RWAIT;
        end
      end
      RWAIT: begin
        if (wbs_cyc_i) begin
          doutCap   = 1'b1;
          stateNext = ACK;
        end else begin
          stateNext = IDLE;
        end
      end
      ACK: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign enterAck  = (state == IDLE) && (stateNext == ACK);
  assign wbs_ack_o = (state == ACK) && wbs_cyc_i;

  // SRAM port 0: strobes live for the ACCESS cycle only, address/data/mask persist.
  always_ff @(posedge wb_clk_i) begin
    if (!reset_n) begin
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= 4'd0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
    end else begin
      sram_csb0 <= ~sramGo;
      sram_web0 <= sramGo ? ~wbs_we_i : 1'b1;
      if (sramGo) begin
        sram_wmask0 <= wbs_sel_i;
        sram_addr0  <= wbs_adr_i[ADDR_W+1:2];
        sram_din0   <= wbs_dat_i[DATA_W-1:0];
      end
    end
  end

  // CTRL register: HOLD bit plus saturating SRAM write counter.
  always_ff @(posedge wb_clk_i) begin
    if (!reset_n) begin
      core_hold <= 1'b1;
      wcount    <= 10'd0;
    end else begin
      if (ctrlWr) begin
        core_hold <= wbs_dat_i[0];
      end
      if (ctrlWr && wbs_dat_i[31]) begin
        wcount <= 10'd0;
      end else if (wcountInc) begin
        wcount <= satInc(wcount);
      end
    end
  end

  // Read data is valid only during the ack cycle and zero otherwise.
  always_ff @(posedge wb_clk_i) begin
    if (!reset_n) begin
      wbs_dat_o <= 32'd0;
    end else if (doutCap) begin
      wbs_dat_o <= 32'(sram_dout0);
    end else if (enterAck) begin
      wbs_dat_o <= ctrlRd ? ctrlReadWord(core_hold, wcount) : 32'd0;
    end else if (state == ACK) begin
      wbs_dat_o <= 32'd0;
    end
  end

endmodule

// File: tb/tb_imem_wb_loader.sv
// Randomized bench for imem_wb_loader: a byte-masked SRAM array, HOLD bit and saturating
// write counter model the expected behaviour; per-scenario tasks compare against it.
module tb_imem_wb_loader;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, datI;
  logic        ack;
  logic [31:0] datO;
  logic        csb0, web0;
  logic [3:0]  wmask0;
  logic [8:0]  addr0;
  logic [31:0] din0;
  logic [31:0] dout0;
  logic        coreHold;

  always #5 clk = ~clk;

  imem_wb_loader #(.BASE_ADDR(BASE), .ADDR_W(9), .DATA_W(32)) dut (
    .wb_clk_i   (clk),
    .reset_n    (reset_n),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (datI),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (datO),
    .sram_csb0  (csb0),
    .sram_web0  (web0),
    .sram_wmask0(wmask0),
    .sram_addr0 (addr0),
    .sram_din0  (din0),
    .sram_dout0 (dout0),
    .core_hold  (coreHold)
  );

  // Physical SRAM stand-in: dout valid the cycle after the chip-select cycle.
  logic [31:0] sramMem [0:511];
  always @(posedge clk) begin
    if (csb0 === 1'b0) begin
      if (web0 === 1'b0) begin
        for (int b = 0; b < 4; b++)
          if (wmask0[b]) sramMem[addr0][8*b +: 8] <= din0[8*b +: 8];
      end else begin
        dout0 <= sramMem[addr0];
      end
    end
  end

  // Reference model state.
  logic [31:0] refMem [0:511];
  logic        refHold;
  int          refWcount;

  int checkCnt, passCnt;

  // Observations of the last bus transfer.
  int          ackCyc, csbCyc, csbCount;
  logic        web0AtCsb, holdAt0, holdAt1;
  logic [8:0]  addrAtCsb;
  logic [31:0] dinAtCsb, rdata;
  logic [3:0]  maskAtCsb;

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldW, input logic [31:0] newW,
                                             input logic [3:0] s);
    logic [31:0] r;
    r = oldW;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = newW[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ctrlWord(input logic h, input int wc);
    return (32'(wc) << 16) | {31'd0, h};
  endfunction

  task automatic refSramWrite(input int w, input logic [31:0] d, input logic [3:0] s);
    if (refHold) begin
      refMem[w] = mergeBytes(refMem[w], d, s);
      if (refWcount < 1023) refWcount++;
    end
  endtask

  // Starts just after a rising edge; returns just after the edge that ends the ack cycle
  // (or the budget), leaving the request asserted so a caller may chain transfers.
  task automatic wbXfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int maxCyc);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; datI = d; sel = s;
    ackCyc = -1; csbCyc = -1; csbCount = 0; rdata = 32'd0;
    holdAt0 = 1'bx; holdAt1 = 1'bx;
    for (int c = 0; c < maxCyc; c++) begin
      @(negedge clk);
      if (c == 0) holdAt0 = coreHold;
      if (c == 1) holdAt1 = coreHold;
      if (csb0 === 1'b0) begin
        if (csbCyc < 0) begin
          csbCyc = c; web0AtCsb = web0; addrAtCsb = addr0; dinAtCsb = din0; maskAtCsb = wmask0;
        end
        csbCount++;
      end
      if (ack === 1'b1) begin
        ackCyc = c; rdata = datO;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wbIdle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'd0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkCnt++;
    if ({csb0, web0, wmask0, addr0, din0, ack, datO, coreHold} !== {1'b1, 1'b1, 4'h0, 9'h0, 32'h0, 1'b0, 32'h0, 1'b1})
      $display("FAIL reset_outputs: got csb=%b web=%b mask=%h addr=%h din=%h ack=%b dat=%h hold=%b want 1 1 0 0 0 0 0 1",
               csb0, web0, wmask0, addr0, din0, ack, datO, coreHold);
    else passCnt++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    refHold = 1'b1; refWcount = 0;
    wbXfer(1'b0, BASE + 32'h800, 32'd0, 4'hF, 10); wbIdle();
    checkCnt++;
    if (ackCyc !== 1) $display("FAIL reset_ctrl_ack_cycle: got %0d want 1", ackCyc); else passCnt++;
    checkCnt++;
    if (rdata !== 32'h0000_0001) $display("FAIL reset_ctrl_read: got %h want 00000001", rdata); else passCnt++;
  endtask

  task automatic test_sram_basic();
    wbXfer(1'b1, BASE + 32'h010, 32'hDEAD_BEEF, 4'hF, 10); wbIdle();
    refSramWrite(4, 32'hDEAD_BEEF, 4'hF);
    checkCnt++;
    if (ackCyc !== 2) $display("FAIL wr_ack_cycle: got %0d want 2", ackCyc); else passCnt++;
    checkCnt++;
    if (csbCyc !== 1 || csbCount !== 1)
      $display("FAIL wr_csb_window: got first=%0d count=%0d want first=1 count=1", csbCyc, csbCount);
    else passCnt++;
    checkCnt++;
    if ({web0AtCsb, addrAtCsb, dinAtCsb, maskAtCsb} !== {1'b0, 9'd4, 32'hDEAD_BEEF, 4'hF})
      $display("FAIL wr_port_values: got web=%b addr=%h din=%h mask=%h want 0 004 deadbeef f",
               web0AtCsb, addrAtCsb, dinAtCsb, maskAtCsb);
    else passCnt++;

    wbXfer(1'b0, BASE + 32'h010, 32'd0, 4'hF, 10);
    checkCnt++;
    if (ackCyc !== 3) $display("FAIL rd_ack_cycle: got %0d want 3", ackCyc); else passCnt++;
    checkCnt++;
    if (rdata !== refMem[4]) $display("FAIL rd_data: got %h want %h", rdata, refMem[4]); else passCnt++;
    checkCnt++;
    if (ack !== 1'b0 || datO !== 32'd0)
      $display("FAIL after_ack_idle: got ack=%b dat=%h want ack=0 dat=0", ack, datO);
    else passCnt++;
    wbIdle();

    wbXfer(1'b1, BASE + 32'h010, 32'h0000_00AA, 4'h1, 10); wbIdle();
    refSramWrite(4, 32'h0000_00AA, 4'h1);
    wbXfer(1'b0, BASE + 32'h010, 32'd0, 4'hF, 10); wbIdle();
    checkCnt++;
    if (rdata !== 32'hDEAD_BEAA) $display("FAIL byte_write: got %h want deadbeaa", rdata); else passCnt++;

    wbXfer(1'b1, BASE + 32'h010, 32'h1234_5678, 4'h0, 10); wbIdle();
    refSramWrite(4, 32'h1234_5678, 4'h0);
    checkCnt++;
    if (csbCount !== 1 || maskAtCsb !== 4'h0)
      $display("FAIL sel0_issued: got count=%0d mask=%h want count=1 mask=0", csbCount, maskAtCsb);
    else passCnt++;
    wbXfer(1'b0, BASE + 32'h010, 32'd0, 4'hF, 10); wbIdle();
    checkCnt++;
    if (rdata !== refMem[4]) $display("FAIL sel0_unchanged: got %h want %h", rdata, refMem[4]); else passCnt++;

    wbXfer(1'b0, BASE + 32'h800, 32'd0, 4'hF, 10); wbIdle();
    checkCnt++;
    if (rdata !== ctrlWord(refHold, refWcount))
      $display("FAIL wcount_basic: got %h want %h", rdata, ctrlWord(refHold, refWcount));
    else passCnt++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int          w;
      logic        isWr;
      logic [31:0] d;
      logic [3:0]  s;
      w = $urandom_range(0, 511); isWr = 1'($urandom_range(0, 1));
      d = $urandom; s = 4'($urandom_range(0, 15));
      wbXfer(isWr, BASE + (32'(w) << 2), d, s, 10);
      if ($urandom_range(0, 1) == 1) wbIdle();
      if (isWr) begin
        refSramWrite(w, d, s);
        checkCnt++;
        if (ackCyc !== 2 || csbCount !== 1 || addrAtCsb !== 9'(w) || maskAtCsb !== s)
          $display("FAIL rand_write[%0d]: got ack=%0d csbs=%0d addr=%h mask=%h want 2 1 %h %h",
                   i, ackCyc, csbCount, addrAtCsb, maskAtCsb, 9'(w), s);
        else passCnt++;
      end else begin
        checkCnt++;
        if (ackCyc !== 3 || rdata !== refMem[w])
          $display("FAIL rand_read[%0d]: got ack=%0d data=%h want 3 %h", i, ackCyc, rdata, refMem[w]);
        else passCnt++;
      end
    end
    wbIdle();
    wbXfer(1'b0, BASE + 32'h800, 32'd0, 4'hF, 10); wbIdle();
    checkCnt++;
    if (rdata !== ctrlWord(refHold, refWcount))
      $display("FAIL rand_wcount: got %h want %h", rdata, ctrlWord(refHold, refWcount));
    else passCnt++;
  endtask

  task automatic test_hold_clear();
    int          w;
    logic [31:0] d;
    wbXfer(1'b1, BASE + 32'h800, 32'h8000_0000, 4'hF, 10); wbIdle();
    refHold = 1'b0; refWcount = 0;
    checkCnt++;
    if (ackCyc !== 1) $display("FAIL ctrl_wr_ack_cycle: got %0d want 1", ackCyc); else passCnt++;
    checkCnt++;
    if (holdAt0 !== 1'b1 || holdAt1 !== 1'b0)
      $display("FAIL hold_timing: got c0=%b c1=%b want c0=1 c1=0", holdAt0, holdAt1);
    else passCnt++;
    wbXfer(1'b0, BASE + 32'h800, 32'd0, 4'hF, 10); wbIdle();
    checkCnt++;
    if (rdata !== ctrlWord(refHold, refWcount))
      $display("FAIL clear_ctrl_read: got %h want %h", rdata, ctrlWord(refHold, refWcount));
    else passCnt++;
    w = $urandom_range(0, 511); d = ~refMem[w];
    wbXfer(1'b1, BASE + (32'(w) << 2), d, 4'hF, 10); wbIdle();
    refSramWrite(w, d, 4'hF);
    checkCnt++;
    if (ackCyc !== 1 || csbCount !== 0)
      $display("FAIL dropped_write: got ack=%0d csbs=%0d want ack=1 csbs=0", ackCyc, csbCount);
    else passCnt++;
    wbXfer(1'b0, BASE + (32'(w) << 2), 32'd0, 4'hF, 10); wbIdle();
    checkCnt++;
    if (ackCyc !== 3 || rdata !== refMem[w])
      $display("FAIL dropped_readback: got ack=%0d data=%h want 3 %h", ackCyc, rdata, refMem[w]);
    else passCnt++;
    wbXfer(1'b1, BASE + 32'h800, 32'h0000_0001, 4'hF, 10); wbIdle();
    refHold = 1'b1;
    checkCnt++;
    if (coreHold !== 1'b1) $display("FAIL hold_restore: got %b want 1", coreHold); else passCnt++;
  endtask

  task automatic test_window();
    wbXfer(1'b0, 32'h3000_1000, 32'd0, 4'hF, 8); wbIdle();
    checkCnt++;
    if (ackCyc !== -1 || csbCount !== 0)
      $display("FAIL outside_read: got ack=%0d csbs=%0d want ack=-1 csbs=0", ackCyc, csbCount);
    else passCnt++;
    wbXfer(1'b1, 32'h2FFF_F800, 32'h8000_0000, 4'hF, 8); wbIdle();
    checkCnt++;
    if (ackCyc !== -1 || coreHold !== 1'b1)
      $display("FAIL outside_write: got ack=%0d hold=%b want ack=-1 hold=1", ackCyc, coreHold);
    else passCnt++;
    wbXfer(1'b0, BASE + 32'h900, 32'd0, 4'hF, 10); wbIdle();
    checkCnt++;
    if (ackCyc !== 1 || rdata !== 32'd0)
      $display("FAIL reserved_read: got ack=%0d data=%h want ack=1 data=0", ackCyc, rdata);
    else passCnt++;
    wbXfer(1'b1, BASE + 32'h804, 32'h8000_0000, 4'hF, 10); wbIdle();
    checkCnt++;
    if (ackCyc !== 1) $display("FAIL reserved_write_ack: got %0d want 1", ackCyc); else passCnt++;
    wbXfer(1'b0, BASE + 32'h800, 32'd0, 4'hF, 10); wbIdle();
    checkCnt++;
    if (rdata !== ctrlWord(refHold, refWcount))
      $display("FAIL window_ctrl_intact: got %h want %h", rdata, ctrlWord(refHold, refWcount));
    else passCnt++;
  endtask

  task automatic test_abort();
    int          w;
    logic [31:0] d;
    // Write abandoned during ACCESS still completes and counts.
    w = $urandom_range(0, 511); d = $urandom;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + (32'(w) << 2); datI = d; sel = 4'hF;
    @(posedge clk); #1;
    wbIdle();
    @(negedge clk);
    checkCnt++;
    if (csb0 !== 1'b0 || ack !== 1'b0)
      $display("FAIL abort_wr_access: got csb=%b ack=%b want csb=0 ack=0", csb0, ack);
    else passCnt++;
    @(posedge clk); #1;
    refSramWrite(w, d, 4'hF);
    @(negedge clk);
    checkCnt++;
    if (ack !== 1'b0) $display("FAIL abort_wr_noack: got %b want 0", ack); else passCnt++;
    @(posedge clk); #1;
    wbXfer(1'b0, BASE + (32'(w) << 2), 32'd0, 4'hF, 10); wbIdle();
    checkCnt++;
    if (rdata !== refMem[w]) $display("FAIL abort_wr_data: got %h want %h", rdata, refMem[w]); else passCnt++;

    // Read abandoned in RWAIT: no ack, next request taken at once.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + (32'(w) << 2); sel = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    wbIdle();
    @(negedge clk);
    checkCnt++;
    if (ack !== 1'b0 || datO !== 32'd0)
      $display("FAIL abort_rd_noack: got ack=%b dat=%h want ack=0 dat=0", ack, datO);
    else passCnt++;
    @(posedge clk); #1;
    wbXfer(1'b0, BASE + 32'h800, 32'd0, 4'hF, 10); wbIdle();
    checkCnt++;
    if (ackCyc !== 1 || rdata !== ctrlWord(refHold, refWcount))
      $display("FAIL abort_then_ctrl: got ack=%0d data=%h want 1 %h", ackCyc, rdata, ctrlWord(refHold, refWcount));
    else passCnt++;
  endtask

  task automatic test_wcount_sat();
    int  badAck;
    time t0, t1;
    wbXfer(1'b1, BASE + 32'h800, 32'h8000_0001, 4'hF, 10); wbIdle();
    refHold = 1'b1; refWcount = 0;
    badAck = 0;
    t0 = $time;
    for (int i = 0; i < 1030; i++) begin
      int          w;
      logic [31:0] d;
      logic [3:0]  s;
      w = $urandom_range(0, 511); d = $urandom; s = 4'($urandom_range(0, 15));
      wbXfer(1'b1, BASE + (32'(w) << 2), d, s, 10);
      refSramWrite(w, d, s);
      if (ackCyc != 2) badAck++;
    end
    t1 = $time;
    wbIdle();
    checkCnt++;
    if (badAck !== 0) $display("FAIL b2b_ack_cycle: got %0d late acks want 0", badAck); else passCnt++;
    checkCnt++;
    if (t1 - t0 !== 64'd30900) $display("FAIL b2b_period: got %0t want 30900 (3 cycles each)", t1 - t0); else passCnt++;
    wbXfer(1'b0, BASE + 32'h800, 32'd0, 4'hF, 10); wbIdle();
    checkCnt++;
    if (rdata[25:16] !== 10'd1023 || rdata !== ctrlWord(refHold, refWcount))
      $display("FAIL wcount_saturate: got %h want %h", rdata, ctrlWord(refHold, refWcount));
    else passCnt++;
    for (int i = 0; i < 8; i++) begin
      int w;
      w = $urandom_range(0, 511);
      wbXfer(1'b0, BASE + (32'(w) << 2), 32'd0, 4'hF, 10); wbIdle();
      checkCnt++;
      if (rdata !== refMem[w]) $display("FAIL sat_readback[%0d]: got %h want %h", w, rdata, refMem[w]); else passCnt++;
    end
  endtask

  task automatic test_reset_mid();
    int          w;
    logic [31:0] d;
    w = $urandom_range(0, 511); d = $urandom;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + (32'(w) << 2); datI = d; sel = 4'hF;
    @(posedge clk); #1;
    reset_n = 1'b0;
    // The SRAM still samples this ACCESS cycle's strobes at the reset edge.
    refMem[w] = d;
    @(posedge clk); #1;
    checkCnt++;
    if (csb0 !== 1'b1 || ack !== 1'b0 || coreHold !== 1'b1)
      $display("FAIL reset_mid: got csb=%b ack=%b hold=%b want 1 0 1", csb0, ack, coreHold);
    else passCnt++;
    @(negedge clk);
    checkCnt++;
    if (ack !== 1'b0) $display("FAIL reset_mid_noack: got %b want 0", ack); else passCnt++;
    @(posedge clk); #1;
    wbIdle();
    reset_n = 1'b1;
    refHold = 1'b1; refWcount = 0;
    wbXfer(1'b0, BASE + 32'h800, 32'd0, 4'hF, 10); wbIdle();
    checkCnt++;
    if (rdata !== ctrlWord(refHold, refWcount))
      $display("FAIL reset_mid_ctrl: got %h want %h", rdata, ctrlWord(refHold, refWcount));
    else passCnt++;
  endtask

  initial begin
    reset_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'd0; adr = 32'd0; datI = 32'd0;
    checkCnt = 0; passCnt = 0; refHold = 1'b1; refWcount = 0;
    for (int i = 0; i < 512; i++) begin
      logic [31:0] v;
      v = $urandom;
      sramMem[i] <= v;
      refMem[i] = v;
    end
    test_reset();
    test_sram_basic();
    test_random();
    test_hold_clear();
    test_window();
    test_abort();
    test_wcount_sat();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

endmodule

// File: doc/imem_wb_loader.md
# imem_wb_loader

Wishbone slave that loads and reads back the SLRV instruction SRAM (sky130_sram_2kbyte_1rw1r_32x512_8) through its read/write port 0, so the management SoC can program instruction memory over the bus instead of through logic-analyzer pins. It sits between the Caravel Wishbone bus and SRAM port 0. A control register holds the SLRV core in reset while a program is loaded; the core fetches over port 1, which this block does not touch.

## Interface
Parameters:
- BASE_ADDR, 32'h3000_0000, base of the 4 KiB decode window; only bits [31:12] are compared.
- ADDR_W, 9, SRAM word-address width (512 words).
- DATA_W, 32, SRAM and bus data width.

Ports:
- wb_clk_i  in  1  clock; all logic is on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic cycle, strobe and write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  registered acknowledge.
- wbs_dat_o  out  32  registered read data.
- sram_csb0  out  1  port-0 chip select, active-low.
- sram_web0  out  1  port-0 write enable, active-low.
- sram_wmask0  out  4  port-0 byte mask.
- sram_addr0  out  ADDR_W  port-0 word address.
- sram_din0  out  DATA_W  port-0 write data.
- sram_dout0  in  DATA_W  port-0 read data.
- core_hold  out  1  drives the SLRV reset; 1 holds the core in reset.

## Operation
Address map, with offsets relative to BASE_ADDR:
- 0x000–0x7FC: SRAM words. sram_addr0 = wbs_adr_i[10:2].
- 0x800: CTRL register.
  - bit0 HOLD, read/write, reset value 1.
  - bits[25:16] WCOUNT, read-only, 10 bits, reset value 0.
  - bit31: write-1-to-clear WCOUNT; reads as 0.
- 0x804–0xFFC: reserved. Reads return 0 and writes are ignored; both are acknowledged.
- Outside the window: no response and no state change.

A request is a cycle in IDLE with wbs_cyc_i & wbs_stb_i & window hit.

FSM states are IDLE, ACCESS, RWAIT and ACK:
- IDLE, SRAM request:
  - Latch addr, din, wmask=wbs_sel_i and web0=~wbs_we_i into the sram_* registers.
  - Go to ACCESS.
  - Exception: a write while HOLD=0 is dropped. The SRAM is not touched, WCOUNT is unchanged, and the FSM goes to ACK.
- IDLE, CTRL or reserved request:
  - A write updates CTRL in this cycle.
  - Go to ACK.
- ACCESS:
  - sram_csb0=0 for exactly this one cycle.
  - A write increments WCOUNT, saturating at 1023, and goes to ACK.
  - A read goes to RWAIT.
- RWAIT:
  - Capture sram_dout0 into wbs_dat_o at the end of the cycle.
  - Go to ACK.
- ACK:
  - wbs_ack_o = wbs_cyc_i for one cycle.
  - Return to IDLE, so ack is never held for two cycles.

Data and side effects:
- CTRL reads load wbs_dat_o when entering ACK.
- wbs_dat_o returns to 0 in the cycle after ack.
- Master abort (wbs_cyc_i low during ACCESS, RWAIT or ACK):
  - An SRAM access that has already started completes and WCOUNT is still updated.
  - ack is suppressed and the FSM returns to IDLE.
- wbs_sel_i=0 on an SRAM write: the access is issued with wmask 0, so no bytes change, but WCOUNT still increments.
- Simultaneous CTRL write of HOLD=0 and bit31=1: both take effect.
- sram_web0 returns to 1 and sram_csb0 stays 1 outside ACCESS.
- sram_addr0, sram_din0 and sram_wmask0 hold their last values.

## Timing
- Reset (reset_n low at a clock edge):
  - State goes to IDLE.
  - sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0.
  - wbs_ack_o=0, wbs_dat_o=0, core_hold=1, WCOUNT=0.
- Reset mid-transaction: the transaction is abandoned with no ack. csb0 deasserts on the same edge.
- Cycle numbering: the request is seen in cycle 0.
- SRAM write: csb0 and web0 low in cycle 1; ack in cycle 2.
- SRAM read: csb0 low in cycle 1; dout0 sampled at the end of cycle 2; ack with data in cycle 3.
- CTRL, reserved and dropped writes: ack in cycle 1.
- Back-to-back: a new request is accepted in the cycle after ack, so the minimum write period is 3 cycles.
- core_hold changes in the cycle after the CTRL write edge.

## Test plan
- Reset with wbs idle: all outputs at their reset values; CTRL read returns 0x0000_0001.
- Write 0xDEADBEEF to BASE+0x010 with sel=4'hF, HOLD=1 → cycle 1 has csb0=0, web0=0, addr0=4, din0=0xDEADBEEF; ack in cycle 2. Reading it back gives ack in cycle 3 with 0xDEADBEEF (SRAM model returning dout0 one cycle after csb). WCOUNT=1.
- Write 0x000000AA with sel=4'h1 to word 4 → read returns 0xDEADBEAA.
- CTRL write 0x8000_0000 → WCOUNT=0 and HOLD cleared, so core_hold=0 one cycle later. A subsequent SRAM write is acked in cycle 1 with csb0 never low; reading that word back shows the old data.
- 1030 writes with HOLD=1 → WCOUNT saturates at 1023. Address 0x3000_1000 → no ack; BASE+0x900 read → ack with 0.
- Drop wbs_cyc_i during RWAIT → no ack and FSM in IDLE next cycle. reset_n low during ACCESS → csb0=1 on the next edge and no ack.
